// File: rtl/sid_bus_ctrl.sv
// sid_bus_ctrl: buffers SPI register writes and replays them on the SID bus, one per phi2 period
module sid_bus_ctrl #(
  parameter int PHI2_DIV    = 100,
  parameter int RST_PERIODS = 16,
  parameter int FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_stb,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       overflow,
  output logic       busy,
  output logic       phi2,
  output logic       sid_rst_n,
  output logic       sid_cs_n,
  output logic       sid_rw,
  output logic [4:0] sid_addr,
  output logic [7:0] sid_data,
  output logic       sid_data_oe
);
  localparam int H     = PHI2_DIV / 2;
  localparam int CW    = $clog2(PHI2_DIV);
  localparam int RW    = $clog2(RST_PERIODS + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {SID_RST, IDLE, WRITE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [RW-1:0] rcnt;
  logic [12:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] count, count_nx;
  logic last, pop, push;
  // phase wrap, FIFO handshake and next state; the issue point is the cnt==0 cycle
  always_comb begin
    last     = cnt == CW'(PHI2_DIV - 1);
    cnt_nx   = last ? '0 : cnt + CW'(1);
    pop      = state != SID_RST && cnt == '0 && count != '0;
    push     = wr_stb && (count != (FIFO_AW+1)'(DEPTH) || pop);
    count_nx = count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    state_nx = state == SID_RST ? ((last && rcnt == RW'(RST_PERIODS - 1)) ? IDLE : SID_RST) :
               cnt == '0        ? (pop ? WRITE : IDLE) : state;
  end
  // FIFO storage; not reset since the pointers define validity
  always_ff @(posedge clk)
    if (push) mem[wp] <= {wr_addr, wr_data};
  // phase counter, sequencer, FIFO pointers and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rcnt        <= '0;
      state       <= SID_RST;
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      phi2        <= 1'b0;
      sid_rst_n   <= 1'b0;
      sid_cs_n    <= 1'b1;
      sid_rw      <= 1'b1;
      sid_addr    <= '0;
      sid_data    <= '0;
      sid_data_oe <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      phi2      <= cnt_nx >= CW'(H);
      state     <= state_nx;
      count     <= count_nx;
      busy      <= count_nx != '0 || state_nx == WRITE;
      sid_rst_n <= state_nx != SID_RST;
      if (state == SID_RST && last) rcnt <= rcnt + RW'(1);
      if (push) wp <= wp + FIFO_AW'(1);
      if (pop) rp <= rp + FIFO_AW'(1);
      if (wr_stb && !push) overflow <= 1'b1;
      if (state != SID_RST && cnt == '0) begin
        sid_rw      <= !pop;
        sid_data_oe <= pop;
        if (pop) {sid_addr, sid_data} <= mem[rp];
      end
      if (state == WRITE && cnt == CW'(1)) sid_cs_n <= 1'b0;
      else if (last) sid_cs_n <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sid_bus_ctrl.sv
// tb_sid_bus_ctrl: directed table-driven checks of sid_bus_ctrl with P=8, two reset periods, depth-4 FIFO
module tb_sid_bus_ctrl;
  logic clk = 1'b0, rst = 1'b1, wr_stb = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic overflow, busy, phi2, sid_rst_n, sid_cs_n, sid_rw, sid_data_oe;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  int ph = 0, cyc = 0, total = 0, passed = 0;
  typedef struct {
    logic cs_n, rw, oe;
    logic [4:0] addr;
    logic [7:0] data;
    logic busy;
  } vec_t;
  vec_t tbl [9];
  sid_bus_ctrl #(.PHI2_DIV(8), .RST_PERIODS(2), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .overflow(overflow), .busy(busy), .phi2(phi2), .sid_rst_n(sid_rst_n),
    .sid_cs_n(sid_cs_n), .sid_rw(sid_rw), .sid_addr(sid_addr), .sid_data(sid_data),
    .sid_data_oe(sid_data_oe)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s cyc=%0d ph=%0d got=%0h want=%0h", name, cyc, ph, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 8;
    cyc++;
  endtask
  task automatic wait_ph(input int k);
    do tick(); while (ph != k);
  endtask
  task automatic push(input logic [4:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_stb  = 1'b1;
    tick();
    wr_stb  = 1'b0;
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 5'h18, 8'h0F, 1'b1};
    for (int i = 1; i < 7; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 5'h18, 8'h0F, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 5'h18, 8'h0F, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 5'h18, 8'h0F, 1'b0};
    tick();
    tick();
    rst = 1'b0;
    ph = 0;
    cyc = 0;
    check("rst_phi2", phi2, 0);
    check("rst_sid_rst_n", sid_rst_n, 0);
    check("rst_cs_n", sid_cs_n, 1);
    check("rst_rw", sid_rw, 1);
    check("rst_addr", sid_addr, 0);
    check("rst_data", sid_data, 0);
    check("rst_oe", sid_data_oe, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    for (int i = 0; i < 20; i++) begin
      check("t1_phi2", phi2, int'(ph >= 4));
      check("t1_sid_rst_n", sid_rst_n, int'(cyc >= 16));
      check("t1_cs_n", sid_cs_n, 1);
      check("t1_oe", sid_data_oe, 0);
      tick();
    end
    push(5'h18, 8'h0F);
    check("t2_busy_queued", busy, 1);
    check("t2_cs_n_queued", sid_cs_n, 1);
    wait_ph(1);
    for (int i = 0; i < 9; i++) begin
      check("t2_cs_n", sid_cs_n, tbl[i].cs_n);
      check("t2_rw", sid_rw, tbl[i].rw);
      check("t2_oe", sid_data_oe, tbl[i].oe);
      check("t2_addr", sid_addr, tbl[i].addr);
      check("t2_data", sid_data, tbl[i].data);
      check("t2_busy", busy, tbl[i].busy);
      tick();
    end
    push(5'h00, 8'h11);
    push(5'h01, 8'h22);
    push(5'h04, 8'h33);
    push(5'h05, 8'h44);
    for (int k = 0; k < 4; k++) begin
      wait_ph(3);
      check("t3_addr", sid_addr, k < 2 ? k : k + 2);
      check("t3_data", sid_data, 8'h11 * (k + 1));
      check("t3_cs_n", sid_cs_n, 0);
      check("t3_rw", sid_rw, 0);
    end
    check("t3_overflow", overflow, 0);
    wait_ph(1);
    check("t3_busy_done", busy, 0);
    check("t3_rw_idle", sid_rw, 1);
    wait_ph(4);
    push(5'h1F, 8'hA5);
    wait_ph(2);
    check("t4_inflight_cs_n", sid_cs_n, 0);
    check("t4_inflight_addr", sid_addr, 5'h1F);
    for (int i = 0; i < 6; i++) push(5'(i + 8), 8'(8'h60 + i));
    check("t4_overflow", overflow, 1);
    for (int k = 0; k < 4; k++) begin
      wait_ph(3);
      check("t4_addr", sid_addr, k + 8);
      check("t4_data", sid_data, 8'h60 + k);
      check("t4_cs_n", sid_cs_n, 0);
    end
    wait_ph(1);
    check("t4_busy_done", busy, 0);
    check("t4_overflow_sticky", overflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ph = 0;
    cyc = 0;
    check("t5_overflow_cleared", overflow, 0);
    check("t5_sid_rst_n", sid_rst_n, 0);
    while (cyc < 3) tick();
    push(5'h02, 8'hC3);
    push(5'h03, 8'h3C);
    check("t5_busy_held", busy, 1);
    check("t5_rst_held", sid_rst_n, 0);
    check("t5_cs_n_held", sid_cs_n, 1);
    while (cyc < 16) tick();
    check("t5_rst_release", sid_rst_n, 1);
    check("t5_cs_n_release", sid_cs_n, 1);
    tick();
    check("t5_w1_addr", sid_addr, 5'h02);
    check("t5_w1_data", sid_data, 8'hC3);
    check("t5_w1_rw", sid_rw, 0);
    check("t5_w1_oe", sid_data_oe, 1);
    wait_ph(3);
    check("t5_w1_cs_n", sid_cs_n, 0);
    wait_ph(1);
    check("t5_w2_addr", sid_addr, 5'h03);
    check("t5_w2_data", sid_data, 8'h3C);
    check("t5_w2_rw", sid_rw, 0);
    tick();
    push(5'h07, 8'h77);
    check("t6_busy_before", busy, 1);
    check("t6_cs_n_before", sid_cs_n, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_cs_n", sid_cs_n, 1);
    check("t6_rw", sid_rw, 1);
    check("t6_oe", sid_data_oe, 0);
    check("t6_sid_rst_n", sid_rst_n, 0);
    check("t6_busy_flushed", busy, 0);
    check("t6_phi2", phi2, 0);
    ph = 0;
    cyc = 0;
    while (cyc < 17) begin
      check("t6_seq_sid_rst_n", sid_rst_n, int'(cyc >= 16));
      check("t6_seq_cs_n", sid_cs_n, 1);
      tick();
    end
    check("t6_after_rw", sid_rw, 1);
    check("t6_after_oe", sid_data_oe, 0);
    check("t6_after_busy", busy, 0);
    check("t6_after_addr", sid_addr, 0);
    wait_ph(3);
    check("t6_no_issue_cs_n", sid_cs_n, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
